// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer: holds one frame of 24-bit colours and streams them,
// index 0 first, to the writepixel serialiser over a pix_valid/pix_busy
// handshake. After the last pixel it holds the line idle for the strip latch
// gap, then pulses frame_done.
module pixel_frame_sequencer #(
    parameter int NUM_PIXELS = 8,
    parameter int ADDR_W     = 3,
    parameter int CLK_HZ     = 12_000_000,
    parameter int LATCH_US   = 80,
    parameter int BUSY_WAIT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              start,
    input  logic              pix_busy,
    output logic [7:0]        pixel_r,
    output logic [7:0]        pixel_g,
    output logic [7:0]        pixel_b,
    output logic              pix_valid,
    output logic              frame_busy,
    output logic              frame_done
);

    localparam int LATCH_CYC = (CLK_HZ / 1_000_000) * LATCH_US;
    localparam int CNT_MAX   = (LATCH_CYC > BUSY_WAIT) ? LATCH_CYC : BUSY_WAIT;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;
    localparam int MEM_AW    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W:0]   NUM_PIX    = (ADDR_W + 1)'(NUM_PIXELS);
    localparam logic [CNT_W-1:0]  BUSY_LAST  = CNT_W'(BUSY_WAIT - 1);
    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_HI,
        WAIT_LO,
        LATCH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  cnt;
    logic [23:0]       mem [NUM_PIXELS];

    // Frame buffer write port; out-of-range indices are dropped.
    // NOTE: the buffer has no reset on purpose -- a reset must not wipe the
    // frame, and leaving it out lets synthesis map it to RAM.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < NUM_PIX)) begin
            mem[wr_addr[MEM_AW-1:0]] <= wr_data;
        end
    end

    // Sequencer FSM: load, strobe, wait for busy rise/fall, then latch gap.
    // NOTE: all state here uses non-blocking assignments, so a buffer read in
    // LOAD sees the value from before any write landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            pixel_r    <= '0;
            pixel_g    <= '0;
            pixel_b    <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    {pixel_r, pixel_g, pixel_b} <= mem[idx[MEM_AW-1:0]];
                    pix_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    cnt   <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (pix_busy) begin
                        state <= WAIT_LO;
                    end else if (cnt == BUSY_LAST) begin
                        // Serialiser never answered: count the pixel as sent.
                        if (idx == LAST_IDX) begin
                            cnt   <= '0;
                            state <= LATCH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!pix_busy) begin
                        if (idx == LAST_IDX) begin
                            cnt   <= '0;
                            state <= LATCH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign frame_busy = (state != IDLE);

endmodule
